req_arbiter: RTL

Round-robin scheduler that lets several asynchronous request inputs (push-buttons or off-chip strobes) share one downstream consumer, such as a counter's increment port. Each input is double-flop synchronized and rising-edge detected, then queued as a pending bit. Pending events are granted one at a time over a valid/ready handshake. The block sits between the board-level inputs and the shared counter datapath.

---
 rtl/req_arbiter_pkg.sv | 16 +
 rtl/sync2_rst.sv | 24 ++
 rtl/req_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/req_arbiter_pkg.sv
// Shared types for the round-robin request arbiter.
// State encoding and index-width helper.
package req_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int N_DEF = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync2_rst.sv
// Vectored two-flop synchronizer with synchronous reset.
// Each bit is an independent async input.
module sync2_rst #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Round-robin arbiter: sync, edge-detect and queue async requests,
// then grant one pending event at a time over valid/ready.
module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ID_W = id_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_async,
  input  logic            ready,
  output logic            valid,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic [N-1:0]    dropped
);

  state_t          state, state_n;
  logic [N-1:0]    sync_q, prev, rise;
  logic [N-1:0]    pending, pending_n;
  logic [N-1:0]    dropped_n, clr, arb_vec;
  logic [N-1:0]    grant_n;
  logic [ID_W-1:0] id_n, ptr, ptr_n;
  logic [ID_W:0]   pk;
  logic            xfer;

  // First set bit at or after p, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] pick(
    input logic [N-1:0]    v,
    input logic [ID_W-1:0] p
  );
    logic [ID_W:0] r;
    int j;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(p) + i) % N;
      if (v[j]) r = {1'b1, ID_W'(j)};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(
    input logic [ID_W-1:0] id
  );
    logic [N-1:0] o;
    o = '0;
    o[id] = 1'b1;
    return o;
  endfunction

  sync2_rst #(.W(N)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_async),
    .q     (sync_q)
  );

  assign rise = sync_q & ~prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prev     <= '0;
      pending  <= '0;
      dropped  <= '0;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_n;
      prev     <= sync_q;
      pending  <= pending_n;
      dropped  <= dropped_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      grant_id <= id_n;
    end
  end

  always_comb begin
    xfer      = (state == OFFER) && ready;
    clr       = xfer ? grant : '0;
    pending_n = (pending & ~clr) | rise;
    dropped_n = dropped | (rise & pending & ~clr);
    ptr_n     = ptr;
    if (xfer) begin
      if (grant_id == ID_W'(N - 1)) ptr_n = '0;
      else ptr_n = grant_id + 1'b1;
    end
    arb_vec = pending & ~clr;
    pk      = pick(arb_vec, ptr_n);
    state_n = state;
    grant_n = grant;
    id_n    = grant_id;
    unique case (state)
      IDLE: begin
        if (pk[ID_W]) begin
          state_n = OFFER;
          grant_n = onehot(pk[ID_W-1:0]);
          id_n    = pk[ID_W-1:0];
        end
      end
      OFFER: begin
        if (xfer) begin
          if (pk[ID_W]) begin
            grant_n = onehot(pk[ID_W-1:0]);
            id_n    = pk[ID_W-1:0];
          end else begin
            state_n = IDLE;
            grant_n = '0;
            id_n    = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == OFFER);
  end

endmodule
